// File: rtl/led_seq_ctrl_pkg.sv
// Shared LED sequencer types: pattern mode encoding (also used by the xDOM
// register decode) and the scan direction state.
package led_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF    = 2'd0,
    LED_MODE_SCAN   = 2'd1,
    LED_MODE_COUNT  = 2'd2,
    LED_MODE_STATIC = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } led_dir_e;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Configuration and LED drive bundle of the LED sequencer; the register
// block is the master, led_seq_ctrl is the slave.
interface led_seq_ctrl_if
  import led_seq_ctrl_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int P_SEL_WIDTH = 2,
  parameter int P_PWM_WIDTH = 8
);
  localparam int POS_W = $clog2(N_LEDS);

  logic                   en;
  led_mode_e              mode;
  logic [P_SEL_WIDTH-1:0] period_sel;
  logic [N_LEDS-1:0]      static_mask;
  logic [P_PWM_WIDTH-1:0] pwm_lvl;
  logic [N_LEDS-1:0]      y;
  logic                   step;
  logic [POS_W-1:0]       pos;

  modport master (
    output en, mode, period_sel, static_mask, pwm_lvl,
    input  y, step, pos
  );

  modport slave (
    input  en, mode, period_sel, static_mask, pwm_lvl,
    output y, step, pos
  );
endinterface

// File: rtl/led_pwm_gate.sv
// Global PWM dimming gate: free-running counter compared against the level.
// Only present when LED_SEQ_PWM_EN is defined.
`ifdef LED_SEQ_PWM_EN
module led_pwm_gate #(
  parameter int P_PWM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_PWM_WIDTH-1:0] pwm_lvl,
  output logic                   gate
);
  localparam logic [P_PWM_WIDTH-1:0] PWM_ONE = {{(P_PWM_WIDTH-1){1'b0}}, 1'b1};

  logic [P_PWM_WIDTH-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
  end

  // All-ones level means fully on, not 255/256 duty.
  assign gate = (pwm_cnt_q < pwm_lvl) || (&pwm_lvl);
endmodule
`endif

// File: rtl/led_seq_ctrl.sv
// LED sequence generator: off / bouncing scan / binary count / static mask,
// stepped by a power-of-two prescaler. Define LED_SEQ_PWM_EN for PWM dimming.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int P_SEL_WIDTH = 2,
  parameter int P_BASE_LOG2 = 22,
  parameter int P_PWM_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  led_seq_ctrl_if.slave bus
);
  localparam int POS_W = $clog2(N_LEDS);
  localparam int PSC_W = P_BASE_LOG2 + (2 ** P_SEL_WIDTH) - 1;

  localparam logic [PSC_W-1:0]  PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] LED_ONE  = {{(N_LEDS-1){1'b0}}, 1'b1};

  // Modular wrap makes the widest selection come out as all-ones.
  function automatic logic [PSC_W-1:0] term_of(input logic [P_SEL_WIDTH-1:0] sel);
    return (PSC_ONE << (P_BASE_LOG2 + int'(sel))) - PSC_ONE;
  endfunction

  led_mode_e         mode_q;
  logic              mode_vld_q;
  logic [PSC_W-1:0]  psc_q,  psc_d;
  logic [POS_W-1:0]  pos_q,  pos_d;
  led_dir_e          dir_q,  dir_d;
  logic [N_LEDS-1:0] cnt_q,  cnt_d;
  logic              step_q, step_d;
  logic [N_LEDS-1:0] y_q,    y_d;
  logic [N_LEDS-1:0] pattern;
  logic              mode_chg;
  logic              pwm_gate;

  // mode_vld_q suppresses a spurious clear on the first edge after reset,
  // where the state is already initial.
  always_comb begin
    psc_d    = psc_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    mode_chg = mode_vld_q && (bus.mode != mode_q);
    if (mode_chg) begin
      psc_d = '0;
      pos_d = '0;
      dir_d = DIR_UP;
      cnt_d = '0;
    end else if (bus.en) begin
      if (psc_q >= term_of(bus.period_sel)) begin
        psc_d  = '0;
        step_d = 1'b1;
        if (mode_q == LED_MODE_SCAN) begin
          if (dir_q == DIR_UP) begin
            pos_d = pos_q + POS_ONE;
            if (pos_d == POS_LAST) dir_d = DIR_DN;
          end else begin
            pos_d = pos_q - POS_ONE;
            if (pos_d == '0) dir_d = DIR_UP;
          end
        end
        if (mode_q == LED_MODE_COUNT) cnt_d = cnt_q + LED_ONE;
      end else begin
        psc_d = psc_q + PSC_ONE;
      end
    end
  end

  always_comb begin
    pattern = '0;
    case (mode_q)
      LED_MODE_SCAN:   pattern = LED_ONE << pos_q;
      LED_MODE_COUNT:  pattern = cnt_q;
      LED_MODE_STATIC: pattern = bus.static_mask;
      default:         pattern = '0;
    endcase
    y_d = bus.en ? (pattern & {N_LEDS{pwm_gate}}) : '0;
  end

`ifdef LED_SEQ_PWM_EN
  led_pwm_gate #(
    .P_PWM_WIDTH (P_PWM_WIDTH)
  ) u_pwm_gate (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_lvl (bus.pwm_lvl),
    .gate    (pwm_gate)
  );
`else
  logic unused_pwm_lvl;
  assign unused_pwm_lvl = ^bus.pwm_lvl;
  assign pwm_gate       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= LED_MODE_OFF;
      mode_vld_q <= 1'b0;
      psc_q      <= '0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      y_q        <= '0;
    end else begin
      mode_q     <= bus.mode;
      mode_vld_q <= 1'b1;
      psc_q      <= psc_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      y_q        <= y_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.step = step_q;
  assign bus.pos  = pos_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with N_LEDS=4, P_BASE_LOG2=2 (T=3 at period_sel=0).
module tb_led_seq_ctrl;
  import led_seq_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;
  int   total;
  int   exp_pos [7] = '{1, 2, 3, 2, 1, 0, 1};

  led_seq_ctrl_if #(.N_LEDS(4), .P_SEL_WIDTH(2), .P_PWM_WIDTH(8)) bus ();

  led_seq_ctrl #(
    .N_LEDS      (4),
    .P_SEL_WIDTH (2),
    .P_BASE_LOG2 (2),
    .P_PWM_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until step is seen (at least one tick); returns the tick count.
  task automatic wait_step(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.step && cnt < max);
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.en          = 1'b0;
    bus.mode        = LED_MODE_OFF;
    bus.period_sel  = 2'd0;
    bus.static_mask = 4'b0000;
    bus.pwm_lvl     = 8'd0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_y", bus.y, 0);
    check("rst_step", bus.step, 0);
    check("rst_pos", bus.pos, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // scan: one clear cycle, then a step every 4 clocks
    bus.mode = LED_MODE_SCAN;
    bus.en   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_step(20, n);
      check("scan_gap", n, (i == 0) ? 5 : 3);
      check("scan_pos", bus.pos, exp_pos[i]);
      tick();
      check("scan_y", bus.y, 32'd1 << exp_pos[i]);
      check("scan_step_w", bus.step, 0);
    end

    // enable hold at pos 2
    wait_step(20, n);
    check("hold_pre_pos", bus.pos, 2);
    tick();
    check("hold_pre_y", bus.y, 4);
    bus.en = 1'b0;
    tick();
    check("hold_y_blank", bus.y, 0);
    check("hold_pos", bus.pos, 2);
    repeat (5) tick();
    check("hold_pos_late", bus.pos, 2);
    check("hold_step", bus.step, 0);
    bus.en = 1'b1;
    tick();
    check("resume_y", bus.y, 4);
    wait_step(20, n);
    check("resume_gap", n, 2);
    check("resume_pos", bus.pos, 3);
    check("pre_rst_y", bus.y, 4);

    // async reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", bus.y, 0);
    check("arst_step", bus.step, 0);
    check("arst_pos", bus.pos, 0);
    #2 rst_n = 1'b1;
    wait_step(20, n);
    check("arst_first_step", n, 4);
    check("arst_pos_up", bus.pos, 1);

    // count with period_sel=1: step every 8 clocks, wrap after 128
    bus.mode       = LED_MODE_COUNT;
    bus.period_sel = 2'd1;
    total = 0;
    for (int i = 1; i <= 16; i++) begin
      wait_step(40, n);
      check("cnt_gap", n, (i == 1) ? 9 : 7);
      total += n;
      tick();
      total += 1;
      check("cnt_y", bus.y, i % 16);
    end
    check("cnt_wrap_clocks", total - 2, 128);

    // period shortened mid-count: psc at 20 with T=31, then T=3
    bus.mode       = LED_MODE_SCAN;
    bus.period_sel = 2'd3;
    repeat (21) tick();
    check("short_quiet", bus.step, 0);
    bus.period_sel = 2'd0;
    wait_step(40, n);
    check("short_first", n, 1);
    check("short_pos1", bus.pos, 1);
    wait_step(20, n);
    check("short_gap1", n, 4);
    check("short_pos2", bus.pos, 2);
    wait_step(20, n);
    check("short_gap2", n, 4);
    check("short_pos3", bus.pos, 3);

    // mode change on the terminal-count cycle: clear wins, no step
    repeat (3) tick();
    bus.mode = LED_MODE_COUNT;
    tick();
    check("chg_term_step", bus.step, 0);
    check("chg_term_pos", bus.pos, 0);
    wait_step(20, n);
    check("chg_term_gap", n, 4);
    tick();
    check("chg_term_y", bus.y, 1);

    // static mask
    bus.mode        = LED_MODE_STATIC;
    bus.static_mask = 4'b1010;
`ifdef LED_SEQ_PWM_EN
    for (int k = 0; k < 3; k++) begin
      int on_cnt;
      int other;
      int lvl;
      int exp_on;
      lvl    = (k == 0) ? 64 : (k == 1) ? 0 : 255;
      exp_on = (k == 0) ? 64 : (k == 1) ? 0 : 256;
      bus.pwm_lvl = 8'(lvl);
      repeat (2) tick();
      on_cnt = 0;
      other  = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        if (bus.y == 4'b1010) on_cnt++;
        else if (bus.y != 4'b0000) other++;
      end
      check("pwm_on_cycles", on_cnt, exp_on);
      check("pwm_other", other, 0);
    end
`else
    bus.pwm_lvl = 8'd0;
    repeat (2) tick();
    check("static_y", bus.y, 4'b1010);
`endif
    bus.pwm_lvl     = 8'd255;
    bus.static_mask = 4'b0101;
    tick();
    check("static_mask_chg", bus.y, 4'b0101);
    bus.en = 1'b0;
    tick();
    check("static_en_low", bus.y, 0);
    bus.en   = 1'b1;
    bus.mode = LED_MODE_OFF;
    repeat (2) tick();
    check("off_y", bus.y, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Parametrised LED sequence generator: drives `N_LEDS` outputs with one of four patterns: off, bouncing scan, binary count or static mask. Patterns advance at a software-selected step rate, with optional global PWM dimming. It is the general successor to the fixed 4-LED scan and colour-cycle blocks. It sits in the top level on the 125 MHz logic clock, configured from xDOM registers, and drives board LEDs directly.

## Interface
- `N_LEDS`, 4, number of LED outputs (≥2)
- `P_SEL_WIDTH`, 2, width of `period_sel`
- `P_BASE_LOG2`, 22, log2 of step period in clocks at `period_sel`=0
- `P_PWM_WIDTH`, 8, PWM level/counter width
- `clk`  in  1  logic clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable; low holds state and blanks `y`
- `mode`  in  2  0 off, 1 scan, 2 count, 3 static
- `period_sel`  in  `P_SEL_WIDTH`  step period = 2^(`P_BASE_LOG2`+`period_sel`) clocks
- `static_mask`  in  `N_LEDS`  pattern for mode 3
- `pwm_lvl`  in  `P_PWM_WIDTH`  global brightness
- `y`  out  `N_LEDS`  LED drive (registered)
- `step`  out  1  one-cycle pulse per pattern advance
- `pos`  out  clog2(`N_LEDS`)  current scan position

## Operation
- Prescaler: counter `psc`, width `P_BASE_LOG2`+2^`P_SEL_WIDTH`−1.
  - Terminal T = 2^(`P_BASE_LOG2`+`period_sel`)−1.
  - If `en` and `psc`≥T: `psc`←0 and the pattern advances. Otherwise `psc`+1.
  - `psc`≥T (not ==) means a period shortened mid-count steps on the next cycle rather than wrapping the counter.
- Scan: `pos` starts at 0, direction up.
  - Each step moves `pos` one place. At `N_LEDS`−1 the direction flips to down; at 0 it flips to up. End LEDs are lit for one step only.
  - N=4 sequence: 0,1,2,3,2,1,0,1…
  - Pattern is one-hot at `pos`.
- Count: counter `cnt` (`N_LEDS` bits) increments per step and wraps from all-ones to 0. Pattern = `cnt`.
- Static: pattern = `static_mask`. Off: pattern = 0.
- Mode change: the cycle after `mode` differs from its registered copy, `psc`, `pos`, direction and `cnt` all clear. The new mode starts from its initial state with a full period.
- `en` low: `psc`, `pos`, direction and `cnt` hold; `y` forced to 0. On re-enable, the sequence resumes exactly where it stopped.
- Simultaneous mode change and terminal count: the mode-change clear wins, and `step` is not pulsed.
- Reset values: `y`=0, `step`=0, `pos`=0, direction up, `cnt`=0, `psc`=0, PWM counter 0.

## Timing
- `step` is registered. It is high for one cycle, on the same edge that `pos`/`cnt` take their new value.
- `y` is registered from pattern and PWM gate, lagging `pos`/`cnt` by one cycle.
- Pulse spacing on `step` is exactly T+1 clocks in steady state.
- `static_mask`, `pwm_lvl` and `en` affect `y` one cycle after sampling.
- Asynchronous reset clears all outputs immediately, with no clock edge required.

## Configuration
- `LED_SEQ_PWM_EN` defined:
  - Free-running `P_PWM_WIDTH`-bit counter `pwm_cnt`.
  - Gate on = (`pwm_cnt` < `pwm_lvl`) OR (`pwm_lvl` all-ones).
  - `y` = pattern AND gate, so level 0 is dark and maximum is fully on.
- Not defined: no PWM counter; `pwm_lvl` is ignored; `y` = pattern (full brightness).

## Structure
- Shared package holds the mode constants (`LED_MODE_OFF`/`SCAN`/`COUNT`/`STATIC`) and the 2-bit mode type, also used by the xDOM register decode.
- One natural sub-module, `led_pwm_gate`: PWM counter and compare producing the gate bit. It is instantiated only under `LED_SEQ_PWM_EN`.

## Test plan
Bench parameters: `N_LEDS`=4, `P_BASE_LOG2`=2.
- **Scan timing:** scan mode, `period_sel`=0, `en`=1 → `step` every 4 clocks; `pos` 0,1,2,3,2,1,0,1; `y` 0001,0010,0100,1000,0100,0010,0001, each one cycle after `pos`.
- **Count wrap:** count mode, `period_sel`=1 → `y` = 0…15 then 0, with a `step` every 8 clocks; the wrap is seen after 128 clocks.
- **Period shortened mid-count:** `period_sel`=3, wait until `psc`=20, then set `period_sel`=0 → `step` on the next cycle, then every 4 clocks.
- **Enable hold:** drop `en` with scan at `pos`=2 → `y`=0 one cycle later and `pos` holds at 2; raise `en` → resumes 2→3 after the remaining prescaler count.
- **PWM dimming** (with `LED_SEQ_PWM_EN`): static `1010`, `pwm_lvl`=64 → `y`=1010 for 64 of every 256 cycles. `pwm_lvl`=0 → `y`=0 always; `pwm_lvl`=255 → `y`=1010 always.
- **Async reset:** assert `rst_n` low mid-scan between edges → `y`, `step`, `pos` go to 0 immediately. After release: `pos`=0, direction up, first `step` 4 clocks later.
